vend_credit_controller: RTL
===========================

# vend_credit_controller

Credit and dispense sequencer for the coin-operated vending datapath. It sits between the synchronized coin switches and the drop indicator and credit display. Each coin insertion is counted once and accumulated into a saturating credit register. When credit covers the price, the block runs a timed drop pulse and deducts the price. As a compile-time option, it returns unspent credit as a train of refund pulses.

## Interface
Parameters:
- PRICE, 4: credit units consumed per drop; range 1..15.
- DROP_CYCLES, 4: number of cycles `drop` is held high per vend; range 1..15.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- coin  input  2  coin code: 00 none, 01 circle (1), 10 triangle (3), 11 pentagon (5). Already synchronous to `clock`.
- refund  input  1  level request to return credit. Used only with REFUND_EN.
- drop  output  1  high during a vend.
- credit  output  4  current registered credit, 0..15. Drives the BCD0 digit of the display.
- busy  output  1  high in the DROP and REFUND states.
- refund_pulse  output  1  one pulse per credit unit returned.

## Operation
Reset (reset_L low, applied immediately):
- credit=0, drop=0, busy=0, refund_pulse=0, state=IDLE, coin_q=00.

Coin detection:
- `coin_q` registers `coin` every cycle.
- A coin event occurs when `coin` is not 00 and `coin_q` is 00. Holding a code counts once.
- A code change without passing through 00 (for example 01 to 11) is not an event.

Credit add:
- On an event in IDLE or DROP: credit_sum = min(credit + value, 15), using 5-bit internal arithmetic.

States:
- IDLE: drop=0, busy=0.
  - If credit ≥ PRICE and the previous state was not DROP: go to DROP. The next credit is credit_sum − PRICE (or credit − PRICE with no event). Load drop_cnt=DROP_CYCLES.
  - Else if REFUND_EN, refund=1 and credit>0: go to REFUND. A drop always has priority over a refund.
  - Else: credit = credit_sum.
- DROP: drop=1, busy=1.
  - Coin events are still added, with saturation.
  - drop_cnt decrements each cycle. When it reaches 1, go to IDLE.
  - IDLE then lasts at least 1 cycle, so back-to-back drops are separated by ≥1 low cycle.
- REFUND (REFUND_EN only): busy=1.
  - refund_pulse alternates 1,0,1,0. Each high cycle decrements credit by 1.
  - Return to IDLE on the cycle after the pulse that brings credit to 0.
  - Coin events in REFUND are discarded, and `coin_q` still tracks `coin`.
  - Deasserting `refund` mid-sequence does not abort the refund.

## Timing
- Coin sampled at edge t: `credit` shows the new value after edge t (1-cycle latency).
- Credit ≥ PRICE registered at edge t: `drop` rises and credit is reduced at edge t+1.
- Drop length: `drop` is high for exactly DROP_CYCLES cycles.
- Simultaneous coin event and DROP entry: add, then saturate, then subtract, in the same edge.
- Refund pulse timing: the first `refund_pulse` is high in the first REFUND cycle. A credit of N needs 2N cycles in REFUND.
- Reset mid-operation: reset_L low in DROP or REFUND forces all outputs to their reset values within the same cycle.
- Outputs are all registered; there are no combinational paths from input to output.

## Configuration
- REFUND_EN defined: the REFUND state is present and `refund` is honored.
- REFUND_EN undefined:
  - The REFUND state is not generated.
  - The `refund` port remains but is ignored.
  - `refund_pulse` is tied to 0.
  - `busy` equals `drop`.

## Test plan
- Reset: hold reset_L=0 with coin=11 → credit=0, drop=0, busy=0. Release reset → nothing happens until coin returns to 00 and is reinserted.
- Edge detect: coin=01 for 5 cycles, then 00 → credit=1. Then 01→11 without passing through 00 → credit stays 1.
- Vend: coin 10, gap, coin 10 → credit 3 then 6. Next cycle: drop=1 for exactly 4 cycles and credit=2. Afterwards drop=0 and busy=0.
- Coin at DROP entry plus saturation (PRICE=4):
  - Credit 3, insert coin 01 → credit 4.
  - Coin 10 arriving on the DROP-entry edge → credit=3.
  - Three coins 11 during the drop → credit saturates at 15.
  - After the drop ends, one low cycle, then drops repeat until credit is 3.
- Refund (REFUND_EN): credit=3, refund=1 for 1 cycle → refund_pulse highs at REFUND cycles 1, 3 and 5; credit goes 3→2→1→0; busy is high for 6 cycles. A coin 11 inserted during REFUND is not counted. Without REFUND_EN: credit stays 3 and refund_pulse stays 0.
- Reset mid-drop: assert reset_L=0 in the second DROP cycle → drop=0 and credit=0 immediately; no residual drop after release.

Source files
------------

// File: rtl/vend_credit_controller_if.sv
// vend_credit_controller_if: coin/refund inputs and drop/credit/busy/refund_pulse
// outputs of the vending credit controller, bundled for connection.
// The controller uses the slave modport; the coin-side driver uses master.
interface vend_credit_controller_if;
  logic [1:0] coin;
  logic       refund;
  logic       drop;
  logic [3:0] credit;
  logic       busy;
  logic       refund_pulse;

  modport master (
    output coin,
    output refund,
    input  drop,
    input  credit,
    input  busy,
    input  refund_pulse
  );

  modport slave (
    input  coin,
    input  refund,
    output drop,
    output credit,
    output busy,
    output refund_pulse
  );
endinterface

// File: rtl/vend_credit_controller.sv
// vend_credit_controller: counts coin insertions into a saturating 4-bit credit,
// runs a DROP_CYCLES-long drop pulse whenever credit covers PRICE, and deducts it.
// Optional feature macro: REFUND_EN builds the REFUND state, which returns the
// remaining credit as one refund_pulse per unit. Without it, refund is ignored,
// refund_pulse stays 0 and busy follows drop.
module vend_credit_controller #(
  parameter int unsigned PRICE       = 4,
  parameter int unsigned DROP_CYCLES = 4
) (
  input logic                     clock,
  input logic                     reset_L,
  vend_credit_controller_if.slave bus
);

  localparam logic [3:0] PRICE_V     = 4'(PRICE);
  localparam logic [3:0] DROP_CNT_V  = 4'(DROP_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DROP   = 2'd1;
`ifdef REFUND_EN
  localparam logic [1:0] ST_REFUND = 2'd2;
`endif

  // Credit units carried by each coin code.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] v;
    case (code)
      2'b01:   v = 5'd1;
      2'b10:   v = 5'd3;
      2'b11:   v = 5'd5;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [3:0] credit_r;
  logic [3:0] credit_nxt_s;
  logic [3:0] credit_sum_s;
  logic [4:0] raw_sum_s;
  logic [4:0] add_s;
  logic [3:0] drop_cnt_r;
  logic [3:0] drop_cnt_nxt_s;
  logic [1:0] coin_q_r;
  logic       coin_armed_r;
  logic       coin_evt_s;
  logic       prev_drop_r;
  logic       drop_r;
  logic       busy_r;
  logic       busy_nxt_s;
  logic       refund_pulse_r;
  logic       pulse_nxt_s;

`ifndef REFUND_EN
  logic unused_refund_s;
  assign unused_refund_s = bus.refund;
`endif

  // Coin edge detect, saturating add and next-state selection.
  always_comb begin
    // A code held through reset is only counted after it has returned to 00.
    coin_evt_s = (bus.coin != 2'b00) && (coin_q_r == 2'b00) && coin_armed_r;
    if (coin_evt_s) begin
      add_s = coin_value(bus.coin);
    end else begin
      add_s = 5'd0;
    end
    raw_sum_s = {1'b0, credit_r} + add_s;
    if (raw_sum_s > 5'd15) begin
      credit_sum_s = 4'd15;
    end else begin
      credit_sum_s = raw_sum_s[3:0];
    end

    state_nxt_s    = state_r;
    credit_nxt_s   = credit_r;
    drop_cnt_nxt_s = drop_cnt_r;
    pulse_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // prev_drop_r guarantees one low cycle between consecutive drops.
        if ((credit_r >= PRICE_V) && !prev_drop_r) begin
          state_nxt_s    = ST_DROP;
          credit_nxt_s   = credit_sum_s - PRICE_V;
          drop_cnt_nxt_s = DROP_CNT_V;
        end
`ifdef REFUND_EN
        else if (bus.refund && (credit_r != 4'd0)) begin
          // First pulse appears in the first REFUND cycle.
          state_nxt_s = ST_REFUND;
          pulse_nxt_s = 1'b1;
        end
`endif
        else begin
          credit_nxt_s = credit_sum_s;
        end
      end
      ST_DROP: begin
        credit_nxt_s = credit_sum_s;
        if (drop_cnt_r == 4'd1) begin
          state_nxt_s    = ST_IDLE;
          drop_cnt_nxt_s = 4'd0;
        end else begin
          drop_cnt_nxt_s = drop_cnt_r - 4'd1;
        end
      end
`ifdef REFUND_EN
      ST_REFUND: begin
        // Coins are ignored here; each pulse cycle removes one unit.
        if (refund_pulse_r) begin
          credit_nxt_s = credit_r - 4'd1;
        end else if (credit_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          pulse_nxt_s = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt_s    = ST_IDLE;
        credit_nxt_s   = 4'd0;
        drop_cnt_nxt_s = 4'd0;
      end
    endcase

`ifdef REFUND_EN
    busy_nxt_s = (state_nxt_s != ST_IDLE);
`else
    busy_nxt_s = (state_nxt_s == ST_DROP);
`endif
  end

  // State, credit, coin history and registered outputs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r        <= ST_IDLE;
      credit_r       <= 4'd0;
      drop_cnt_r     <= 4'd0;
      coin_q_r       <= 2'b00;
      coin_armed_r   <= 1'b0;
      prev_drop_r    <= 1'b0;
      drop_r         <= 1'b0;
      busy_r         <= 1'b0;
      refund_pulse_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      credit_r       <= credit_nxt_s;
      drop_cnt_r     <= drop_cnt_nxt_s;
      coin_q_r       <= bus.coin;
      coin_armed_r   <= coin_armed_r | (bus.coin == 2'b00);
      prev_drop_r    <= (state_r == ST_DROP);
      drop_r         <= (state_nxt_s == ST_DROP);
      busy_r         <= busy_nxt_s;
      refund_pulse_r <= pulse_nxt_s;
    end
  end

  assign bus.drop         = drop_r;
  assign bus.credit       = credit_r;
  assign bus.busy         = busy_r;
  assign bus.refund_pulse = refund_pulse_r;

endmodule
